// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Load and stream bus of the systolic operand feeder.
//   ld_valid/ld_ready  element write handshake (ready only while the feeder idles)
//   ld_sel             0 = matrix A, 1 = matrix B
//   ld_row/ld_col      element coordinates
//   ld_data            element value
//   start              request a streaming pass
//   busy/done          pass in progress / one-cycle end-of-pass pulse
//   a_out/b_out        skewed left-edge and top-edge lanes, lane i at [i*DW +: DW]
//   en                 array enable
// master = the controller that loads operands, slave = the feeder.
// -----------------------------------------------------------------------------
interface systolic_feeder_if #(
   parameter int N  = 3,
   parameter int DW = 32
);
   localparam int RW = $clog2(N);

   logic            ld_valid;
   logic            ld_ready;
   logic            ld_sel;
   logic [RW-1:0]   ld_row;
   logic [RW-1:0]   ld_col;
   logic [DW-1:0]   ld_data;
   logic            start;
   logic            busy;
   logic            done;
   logic [N*DW-1:0] a_out;
   logic [N*DW-1:0] b_out;
   logic            en;

   modport master (
      output ld_valid, ld_sel, ld_row, ld_col, ld_data, start,
      input  ld_ready, busy, done, a_out, b_out, en
   );

   modport slave (
      input  ld_valid, ld_sel, ld_row, ld_col, ld_data, start,
      output ld_ready, busy, done, a_out, b_out, en
   );
endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Operand feeder for an NxN systolic multiply array. Holds two NxN operand
// matrices written one element at a time. On start it streams row i of A into
// left lane i and column j of B into top lane j, each delayed by its lane index
// (diagonal skew), holding en high for 3N-2 cycles, then pulses done.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   systolic_feeder_if.slave (load handshake, start/busy/done, lanes, en)
// -----------------------------------------------------------------------------
module systolic_feeder #(
   parameter int N  = 3,
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rstn,
   systolic_feeder_if.slave  bus
);
   localparam int RW   = $clog2(N);
   localparam int CW   = $clog2(3*N-1);
   localparam int LAST = 3*N-3;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t          state_reg, state_next;
   logic [CW-1:0]   t_reg, t_next;

   logic [DW-1:0]   mem_a [N][N];
   logic [DW-1:0]   mem_b [N][N];

   logic            wr_fire;
   int              step_next;

   logic [N*DW-1:0] a_calc, b_calc;
   logic [N*DW-1:0] a_out_reg, a_out_next;
   logic [N*DW-1:0] b_out_reg, b_out_next;
   logic            en_reg, en_next;
   logic            done_reg, done_next;

   // Writes only land while idle; coordinates outside the matrix are dropped.
   assign wr_fire = bus.ld_valid && (state_reg == IDLE) &&
                    (int'(bus.ld_row) < N) && (int'(bus.ld_col) < N);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               mem_a[r][c] <= '0;
               mem_b[r][c] <= '0;
            end
         end
      end else if (wr_fire) begin
         if (bus.ld_sel)
            mem_b[bus.ld_row][bus.ld_col] <= bus.ld_data;
         else
            mem_a[bus.ld_row][bus.ld_col] <= bus.ld_data;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
         t_reg     <= '0;
      end else begin
         state_reg <= state_next;
         t_reg     <= t_next;
      end
   end

   // ---------------- FSM: next state ----------------
   // t_reg is the step currently on the lanes; it is held at 0 outside RUN.
   always_comb begin
      state_next = state_reg;
      t_next     = '0;
      case (state_reg)
         IDLE: if (bus.start) state_next = RUN;
         RUN: begin
            if (t_reg == CW'(LAST)) state_next = FIN;
            else                    t_next     = t_reg + CW'(1);
         end
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Step whose operands are registered at the coming edge.
   assign step_next = (state_reg == RUN) ? int'(t_reg) + 1 : 0;

   // Lane i of A carries A[i][s-i]; lane j of B carries B[s-j][j]. The load
   // port is bypassed into the read so a write accepted together with start is
   // already seen by step 0.
   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [DW-1:0] a_val, b_val;

      always_comb begin
         a_val = '0;
         b_val = '0;
         for (int k = 0; k < N; k++) begin
            if (step_next == gi + k) begin
               if (wr_fire && !bus.ld_sel &&
                   int'(bus.ld_row) == gi && int'(bus.ld_col) == k)
                  a_val = bus.ld_data;
               else
                  a_val = mem_a[gi][k];
               if (wr_fire && bus.ld_sel &&
                   int'(bus.ld_row) == k && int'(bus.ld_col) == gi)
                  b_val = bus.ld_data;
               else
                  b_val = mem_b[k][gi];
            end
         end
      end

      assign a_calc[gi*DW +: DW] = a_val;
      assign b_calc[gi*DW +: DW] = b_val;
   end

   // ---------------- FSM: outputs ----------------
   // Steps beyond 2N-2 fall outside every lane window and produce zeros
   // naturally, giving the drain cycles with en still high.
   always_comb begin
      en_next    = (state_next == RUN);
      done_next  = (state_next == FIN);
      a_out_next = en_next ? a_calc : '0;
      b_out_next = en_next ? b_calc : '0;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_out_reg <= '0;
         b_out_reg <= '0;
         en_reg    <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         a_out_reg <= a_out_next;
         b_out_reg <= b_out_next;
         en_reg    <= en_next;
         done_reg  <= done_next;
      end
   end

   assign bus.a_out    = a_out_reg;
   assign bus.b_out    = b_out_reg;
   assign bus.en       = en_reg;
   assign bus.done     = done_reg;
   assign bus.busy     = (state_reg != IDLE);
   assign bus.ld_ready = (state_reg == IDLE);

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Scoreboard bench: each accepted start pushes the expected per-cycle lane
// frames (from a reference copy of the operand matrices) and the expected
// product matrix. A negedge monitor pops frames while busy, rebuilds the array
// result from the observed lanes and compares it at done.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;
   localparam int N     = 3;
   localparam int DW    = 32;
   localparam int RW    = $clog2(N);
   localparam int STEPS = 3*N-2;

   typedef struct {
      logic [N*DW-1:0] a;
      logic [N*DW-1:0] b;
      logic            en;
      logic            done;
   } frame_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   systolic_feeder_if #(.N(N), .DW(DW)) bus ();
   systolic_feeder #(.N(N), .DW(DW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   logic [DW-1:0] ma [N][N];
   logic [DW-1:0] mb [N][N];
   frame_t        fq [$];
   logic [63:0]   cq [$];
   int            exp_done = 0;
   int            done_cnt = 0;

   // ---------------- monitor ----------------
   logic [DW-1:0] ha [STEPS][N];
   logic [DW-1:0] hb [STEPS][N];
   int            mstep = 0;
   frame_t        f;
   logic [63:0]   acc, cexp;

   always @(negedge clk) begin
      if (!rstn) begin
         fq.delete();
         cq.delete();
         mstep = 0;
      end else if (bus.busy) begin
         if (fq.size() == 0) begin
            chk("frame_underflow", 1, 0);
         end else begin
            f = fq.pop_front();
            chk("a_lanes", bus.a_out, f.a);
            chk("b_lanes", bus.b_out, f.b);
            chk("en", bus.en, f.en);
            chk("done", bus.done, f.done);
            if (!f.done) begin
               if (mstep < STEPS)
                  for (int i = 0; i < N; i++) begin
                     ha[mstep][i] = bus.a_out[i*DW +: DW];
                     hb[mstep][i] = bus.b_out[i*DW +: DW];
                  end
               mstep++;
            end else begin
               done_cnt++;
               // PE(i,j) sees lane a_i delayed by j and lane b_j delayed by i.
               for (int i = 0; i < N; i++)
                  for (int j = 0; j < N; j++) begin
                     acc = '0;
                     for (int t = 0; t < STEPS; t++)
                        if (t - j >= 0 && t - i >= 0)
                           acc += 64'(ha[t-j][i]) * 64'(hb[t-i][j]);
                     if (cq.size() == 0) chk("c_underflow", 1, 0);
                     else begin
                        cexp = cq.pop_front();
                        chk($sformatf("c%0d%0d", i, j), acc, cexp);
                     end
                  end
               mstep = 0;
            end
         end
      end else begin
         chk("idle_en", bus.en, 0);
         chk("idle_done", bus.done, 0);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pass();
      frame_t      e;
      logic [63:0] s;
      for (int t = 0; t < STEPS; t++) begin
         e.a = '0; e.b = '0; e.en = 1'b1; e.done = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (t - i >= 0 && t - i < N) begin
               e.a[i*DW +: DW] = ma[i][t-i];
               e.b[i*DW +: DW] = mb[t-i][i];
            end
         end
         fq.push_back(e);
      end
      e.a = '0; e.b = '0; e.en = 1'b0; e.done = 1'b1;
      fq.push_back(e);
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = '0;
            for (int k = 0; k < N; k++) s += 64'(ma[i][k]) * 64'(mb[k][j]);
            cq.push_back(s);
         end
   endtask

   task automatic load(input logic sel, input int r, input int c, input logic [DW-1:0] d);
      bus.ld_valid = 1'b1;
      bus.ld_sel   = sel;
      bus.ld_row   = RW'(r);
      bus.ld_col   = RW'(c);
      bus.ld_data  = d;
      chk("load_ready", bus.ld_ready, 1);
      if (r < N && c < N) begin
         if (sel) mb[r][c] = d;
         else     ma[r][c] = d;
      end
      tick();
      bus.ld_valid = 1'b0;
   endtask

   // mode 0: plain, 1: write A[0][0]=wd with start, 2: poke during RUN,
   // 3: reset at step 2
   task automatic run_pass(input int mode, input logic [DW-1:0] wd);
      bus.start = 1'b1;
      if (mode == 1) begin
         bus.ld_valid = 1'b1; bus.ld_sel = 1'b0;
         bus.ld_row = '0; bus.ld_col = '0; bus.ld_data = wd;
         ma[0][0] = wd;
      end
      chk("start_ready", bus.ld_ready, 1);
      push_pass();
      tick();
      bus.start = 1'b0;
      bus.ld_valid = 1'b0;
      for (int c = 1; c <= 3*N-1; c++) begin
         if (mode == 2 && c == 2) begin
            bus.ld_valid = 1'b1; bus.ld_sel = 1'b0;
            bus.ld_row = '0; bus.ld_col = '0; bus.ld_data = 32'hDEAD;
            bus.start = 1'b1;
            chk("busy_ready", bus.ld_ready, 0);
            chk("busy_flag", bus.busy, 1);
         end
         if (mode == 2 && c == 4) begin
            bus.ld_valid = 1'b0;
            bus.start = 1'b0;
         end
         if (mode == 3 && c == 3) begin
            rstn = 1'b0;
            #1;
            chk("rst_a", bus.a_out, 0);
            chk("rst_b", bus.b_out, 0);
            chk("rst_en", bus.en, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            @(negedge clk);
            @(posedge clk);
            #1;
            rstn = 1'b1;
            for (int r = 0; r < N; r++)
               for (int k = 0; k < N; k++) begin
                  ma[r][k] = '0;
                  mb[r][k] = '0;
               end
            tick();
            chk("rst_ready", bus.ld_ready, 1);
            chk("rst_done_count", done_cnt, exp_done);
            return;
         end
         tick();
      end
      exp_done++;
      chk("ready_after_pass", bus.ld_ready, 1);
      chk("done_count", done_cnt, exp_done);
   endtask

   // ---------------- sequence ----------------
   initial begin
      bus.ld_valid = 1'b0; bus.ld_sel = 1'b0; bus.ld_row = '0;
      bus.ld_col = '0; bus.ld_data = '0; bus.start = 1'b0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r][c] = '0;
            mb[r][c] = '0;
         end
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      tick();
      chk("reset_ready", bus.ld_ready, 1);
      chk("reset_busy", bus.busy, 0);
      chk("reset_en", bus.en, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_a", bus.a_out, 0);
      chk("reset_b", bus.b_out, 0);

      // identity A, counting B
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            load(1'b0, r, c, (r == c) ? 32'd1 : 32'd0);
            load(1'b1, r, c, DW'(3*r + c + 1));
         end
      run_pass(0, '0);

      // write together with start
      run_pass(1, 32'h55);

      // writes and start while busy are ignored
      run_pass(2, '0);
      run_pass(0, '0);

      // out-of-range writes leave storage untouched
      load(1'b0, 3, 0, 32'h99);
      load(1'b1, 1, 3, 32'h77);
      run_pass(0, '0);

      // general data, then back-to-back passes
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            load(1'b0, r, c, $urandom_range(0, 1000));
      run_pass(0, '0);
      run_pass(0, '0);

      // reset at step 2, then a pass over cleared storage
      run_pass(3, '0);
      run_pass(0, '0);

      repeat (3) tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
